// File: rtl/pci_cfg_target_ctrl_pkg.sv
// Shared types and command codes for the type-0 PCI configuration target.
package pci_cfg_target_ctrl_pkg;

    localparam logic [3:0] CMD_CFG_RD = 4'b1010;
    localparam logic [3:0] CMD_CFG_WR = 4'b1011;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_DATA  = 3'd1,
        RD_FETCH = 3'd2,
        RD_DATA  = 3'd3,
        TAR      = 3'd4
    } cfg_tgt_state_t;

    // Access presented to pci_cfg alongside the cfg_enable strobe.
    typedef struct packed {
        logic        iswrite;
        logic [5:0]  offset;
        logic [31:0] write_val;
        logic [3:0]  byte_en;
    } cfg_req_t;

endpackage

// File: rtl/pci_cfg_target_ctrl_if.sv
// Bus-side (pad block) and register-side (pci_cfg) signals of the config target.
interface pci_cfg_target_ctrl_if;

    // PCI bus, as sampled from / driven to the pad block
    logic        frame_n;
    logic        irdy_n;
    logic        idsel;
    logic [31:0] ad_in;
    logic [3:0]  cbe_n;
    logic [31:0] ad_out;
    logic        ad_oe;
    logic        devsel_n;
    logic        trdy_n;
    logic        stop_n;
    logic        ctl_oe;

    // pci_cfg register file access
    logic        cfg_enable;
    logic        cfg_iswrite;
    logic [5:0]  cfg_offset;
    logic [31:0] cfg_write_val;
    logic [3:0]  cfg_byte_en;
    logic [31:0] cfg_read_val;

    // Target side (the sequencer)
    modport slave (
        input  frame_n, irdy_n, idsel, ad_in, cbe_n, cfg_read_val,
        output ad_out, ad_oe, devsel_n, trdy_n, stop_n, ctl_oe,
        output cfg_enable, cfg_iswrite, cfg_offset, cfg_write_val, cfg_byte_en
    );

    // Bus master / register file side
    modport master (
        output frame_n, irdy_n, idsel, ad_in, cbe_n, cfg_read_val,
        input  ad_out, ad_oe, devsel_n, trdy_n, stop_n, ctl_oe,
        input  cfg_enable, cfg_iswrite, cfg_offset, cfg_write_val, cfg_byte_en
    );

endinterface

// File: rtl/pci_cfg_target_ctrl.sv
// Type-0 PCI configuration-cycle target sequencer: decodes config address
// phases, drives DEVSEL#/TRDY#/STOP#/AD and issues one-cycle pci_cfg strobes.
// Single data phase only; bursts are ended with disconnect-with-data.
module pci_cfg_target_ctrl
    import pci_cfg_target_ctrl_pkg::*;
#(
    parameter logic [2:0] FUNCTION_NUM = 3'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    pci_cfg_target_ctrl_if.slave  bus
);

    // Config address decode: IDSEL, type-0 encoding, function and command.
    function automatic logic f_cfg_hit(
        input logic       idsel,
        input logic [1:0] ad_type,
        input logic [2:0] ad_func,
        input logic [3:0] cmd_n
    );
        return idsel && (ad_type == 2'b00) && (ad_func == FUNCTION_NUM) &&
               ((cmd_n == CMD_CFG_RD) || (cmd_n == CMD_CFG_WR));
    endfunction

    cfg_tgt_state_t r_state;
    cfg_req_t       r_req;
    logic           r_frame_q;
    logic           r_irdy_q;
    logic [31:0]    r_ad_out;
    logic           r_ad_oe;
    logic           r_devsel_n;
    logic           r_trdy_n;
    logic           r_stop_n;
    logic           r_ctl_oe;
    logic           r_cfg_enable;

    logic           w_addr_phase;
    logic           w_hit;

    // An address phase is the first FRAME# low after a fully idle bus.
    assign w_addr_phase = !bus.frame_n && r_frame_q && r_irdy_q;
    assign w_hit        = w_addr_phase &&
                          f_cfg_hit(bus.idsel, bus.ad_in[1:0], bus.ad_in[10:8], bus.cbe_n);

    // Sequencer: state, bus drive values and pci_cfg strobe, all registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_req        <= '0;
            r_frame_q    <= 1'b1;
            r_irdy_q     <= 1'b1;
            r_ad_out     <= '0;
            r_ad_oe      <= 1'b0;
            r_devsel_n   <= 1'b1;
            r_trdy_n     <= 1'b1;
            r_stop_n     <= 1'b1;
            r_ctl_oe     <= 1'b0;
            r_cfg_enable <= 1'b0;
        end else begin
            r_frame_q    <= bus.frame_n;
            r_irdy_q     <= bus.irdy_n;
            r_cfg_enable <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_ctl_oe <= 1'b0;
                    if (w_hit) begin
                        // Fast DEVSEL#: claim the cycle right after the address phase.
                        r_ctl_oe       <= 1'b1;
                        r_devsel_n     <= 1'b0;
                        r_req.iswrite  <= bus.cbe_n[0];
                        r_req.offset   <= bus.ad_in[7:2];
                        if (bus.cbe_n[0]) begin
                            // FRAME# is low here, so STOP# goes out with TRDY# in case
                            // the master intends a burst.
                            r_state  <= WR_DATA;
                            r_trdy_n <= 1'b0;
                            r_stop_n <= 1'b0;
                        end else begin
                            // Read strobe goes out during the AD turnaround cycle.
                            r_state      <= RD_FETCH;
                            r_cfg_enable <= 1'b1;
                        end
                    end
                end

                WR_DATA: begin
                    if (!bus.irdy_n) begin
                        // Data transferred (TRDY# already low): capture and strobe.
                        r_cfg_enable      <= 1'b1;
                        r_req.write_val   <= bus.ad_in;
                        r_req.byte_en     <= ~bus.cbe_n;
                        r_state           <= TAR;
                        r_devsel_n        <= 1'b1;
                        r_trdy_n          <= 1'b1;
                        r_stop_n          <= 1'b1;
                    end else if (bus.frame_n) begin
                        // Master abandoned the cycle; no write reaches pci_cfg.
                        r_state    <= TAR;
                        r_devsel_n <= 1'b1;
                        r_trdy_n   <= 1'b1;
                        r_stop_n   <= 1'b1;
                    end else begin
                        r_stop_n <= 1'b0;
                    end
                end

                RD_FETCH: begin
                    // pci_cfg data is sampled once here and held for the data phase.
                    r_state  <= RD_DATA;
                    r_ad_out <= bus.cfg_read_val;
                    r_ad_oe  <= 1'b1;
                    r_trdy_n <= 1'b0;
                    r_stop_n <= bus.frame_n;
                end

                RD_DATA: begin
                    if (!bus.irdy_n || bus.frame_n) begin
                        // Completion or master abandon both release the bus.
                        r_state    <= TAR;
                        r_ad_oe    <= 1'b0;
                        r_devsel_n <= 1'b1;
                        r_trdy_n   <= 1'b1;
                        r_stop_n   <= 1'b1;
                    end else begin
                        r_stop_n <= 1'b0;
                    end
                end

                TAR: begin
                    // Control lines were driven high for one cycle; now float them.
                    r_state  <= IDLE;
                    r_ctl_oe <= 1'b0;
                end

                default: begin
                    r_state    <= IDLE;
                    r_ad_oe    <= 1'b0;
                    r_ctl_oe   <= 1'b0;
                    r_devsel_n <= 1'b1;
                    r_trdy_n   <= 1'b1;
                    r_stop_n   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ad_out        = r_ad_out;
    assign bus.ad_oe         = r_ad_oe;
    assign bus.devsel_n      = r_devsel_n;
    assign bus.trdy_n        = r_trdy_n;
    assign bus.stop_n        = r_stop_n;
    assign bus.ctl_oe        = r_ctl_oe;
    assign bus.cfg_enable    = r_cfg_enable;
    assign bus.cfg_iswrite   = r_req.iswrite;
    assign bus.cfg_offset    = r_req.offset;
    assign bus.cfg_write_val = r_req.write_val;
    assign bus.cfg_byte_en   = r_req.byte_en;

endmodule

// File: tb/tb_pci_cfg_target_ctrl.sv
// Self-checking bench for pci_cfg_target_ctrl: directed and random config
// transactions, checked cycle by cycle against transaction-level expectations.
module tb_pci_cfg_target_ctrl;
    import pci_cfg_target_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_exp_strobes = 0;
    int   n_seen_strobes = 0;
    int   n_consec = 0;
    logic prev_en = 1'b0;

    pci_cfg_target_ctrl_if bus();

    pci_cfg_target_ctrl #(.FUNCTION_NUM(3'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    // Strobe monitor: total count and back-to-back detection.
    always @(negedge clk) begin
        if (bus.cfg_enable === 1'b1) begin
            n_seen_strobes++;
            if (prev_en) n_consec++;
        end
        prev_en = (bus.cfg_enable === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Present one bus cycle, let the DUT clock it, sample mid-cycle.
    task automatic drive(input logic f, input logic i, input logic sel,
                         input logic [31:0] ad, input logic [3:0] cbe);
        bus.frame_n = f;
        bus.irdy_n  = i;
        bus.idsel   = sel;
        bus.ad_in   = ad;
        bus.cbe_n   = cbe;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(1'b1, 1'b1, 1'($urandom), $urandom, 4'($urandom));
    endtask

    function automatic logic [31:0] cfg_addr(input logic [2:0] func, input logic [5:0] off);
        logic [31:0] a;
        a = $urandom;
        a[10:8] = func;
        a[7:2]  = off;
        a[1:0]  = 2'b00;
        return a;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, ".ad_out"},  bus.ad_out, 32'h0);
        chk({tag, ".ad_oe"},   {31'h0, bus.ad_oe}, 32'h0);
        chk({tag, ".ctl_oe"},  {31'h0, bus.ctl_oe}, 32'h0);
        chk({tag, ".devsel"},  {31'h0, bus.devsel_n}, 32'h1);
        chk({tag, ".trdy"},    {31'h0, bus.trdy_n}, 32'h1);
        chk({tag, ".stop"},    {31'h0, bus.stop_n}, 32'h1);
        chk({tag, ".en"},      {31'h0, bus.cfg_enable}, 32'h0);
        chk({tag, ".iswr"},    {31'h0, bus.cfg_iswrite}, 32'h0);
        chk({tag, ".off"},     {26'h0, bus.cfg_offset}, 32'h0);
        chk({tag, ".wval"},    bus.cfg_write_val, 32'h0);
        chk({tag, ".be"},      {28'h0, bus.cfg_byte_en}, 32'h0);
    endtask

    // Turnaround cycle after the data phase: control driven high, AD floated.
    task automatic chk_tar(input string tag);
        chk({tag, ".tar_devsel"}, {31'h0, bus.devsel_n}, 32'h1);
        chk({tag, ".tar_trdy"},   {31'h0, bus.trdy_n}, 32'h1);
        chk({tag, ".tar_stop"},   {31'h0, bus.stop_n}, 32'h1);
        chk({tag, ".tar_ctloe"},  {31'h0, bus.ctl_oe}, 32'h1);
        chk({tag, ".tar_adoe"},   {31'h0, bus.ad_oe}, 32'h0);
    endtask

    task automatic chk_released(input string tag);
        chk({tag, ".rel_ctloe"}, {31'h0, bus.ctl_oe}, 32'h0);
        chk({tag, ".rel_en"},    {31'h0, bus.cfg_enable}, 32'h0);
    endtask

    task automatic do_write(input logic [5:0] off, input logic [31:0] data, input logic [3:0] be,
                            input int waits, input bit burst, input bit abandon);
        idle(2);
        drive(1'b0, 1'b1, 1'b1, cfg_addr(3'd0, off), CMD_CFG_WR);
        chk("wr.devsel", {31'h0, bus.devsel_n}, 32'h0);
        chk("wr.ctloe",  {31'h0, bus.ctl_oe}, 32'h1);
        chk("wr.trdy",   {31'h0, bus.trdy_n}, 32'h0);
        chk("wr.adoe",   {31'h0, bus.ad_oe}, 32'h0);
        chk("wr.en0",    {31'h0, bus.cfg_enable}, 32'h0);
        if (burst) chk("wr.stop", {31'h0, bus.stop_n}, 32'h0);
        for (int w = 0; w < waits; w++) begin
            drive(1'b0, 1'b1, 1'($urandom), $urandom, 4'($urandom));
            chk("wr.wait_trdy", {31'h0, bus.trdy_n}, 32'h0);
            chk("wr.wait_dev",  {31'h0, bus.devsel_n}, 32'h0);
            chk("wr.wait_en",   {31'h0, bus.cfg_enable}, 32'h0);
            if (burst) chk("wr.wait_stop", {31'h0, bus.stop_n}, 32'h0);
        end
        if (abandon) begin
            drive(1'b1, 1'b1, 1'b0, $urandom, 4'($urandom));
            chk("wr.abn_en", {31'h0, bus.cfg_enable}, 32'h0);
        end else begin
            drive(burst ? 1'b0 : 1'b1, 1'b0, 1'b0, data, ~be);
            n_exp_strobes++;
            chk("wr.en",   {31'h0, bus.cfg_enable}, 32'h1);
            chk("wr.iswr", {31'h0, bus.cfg_iswrite}, 32'h1);
            chk("wr.off",  {26'h0, bus.cfg_offset}, {26'h0, off});
            chk("wr.val",  bus.cfg_write_val, data);
            chk("wr.be",   {28'h0, bus.cfg_byte_en}, {28'h0, be});
        end
        chk_tar("wr");
        idle(1);
        chk_released("wr");
    endtask

    task automatic do_read(input logic [5:0] off, input logic [31:0] val,
                           input int waits, input bit burst, input bit abandon);
        bus.cfg_read_val = val;
        idle(2);
        drive(1'b0, 1'b1, 1'b1, cfg_addr(3'd0, off), CMD_CFG_RD);
        n_exp_strobes++;
        chk("rd.en",     {31'h0, bus.cfg_enable}, 32'h1);
        chk("rd.iswr",   {31'h0, bus.cfg_iswrite}, 32'h0);
        chk("rd.off",    {26'h0, bus.cfg_offset}, {26'h0, off});
        chk("rd.devsel", {31'h0, bus.devsel_n}, 32'h0);
        chk("rd.trdy1",  {31'h0, bus.trdy_n}, 32'h1);
        chk("rd.adoe1",  {31'h0, bus.ad_oe}, 32'h0);
        chk("rd.ctloe",  {31'h0, bus.ctl_oe}, 32'h1);
        drive(1'b0, 1'b1, 1'($urandom), $urandom, 4'($urandom));
        chk("rd.trdy2",  {31'h0, bus.trdy_n}, 32'h0);
        chk("rd.adoe2",  {31'h0, bus.ad_oe}, 32'h1);
        chk("rd.adout",  bus.ad_out, val);
        chk("rd.en2",    {31'h0, bus.cfg_enable}, 32'h0);
        if (burst) chk("rd.stop", {31'h0, bus.stop_n}, 32'h0);
        bus.cfg_read_val = $urandom;
        for (int w = 0; w < waits; w++) begin
            drive(1'b0, 1'b1, 1'($urandom), $urandom, 4'($urandom));
            chk("rd.wait_trdy", {31'h0, bus.trdy_n}, 32'h0);
            chk("rd.wait_ad",   bus.ad_out, val);
            chk("rd.wait_adoe", {31'h0, bus.ad_oe}, 32'h1);
            chk("rd.wait_en",   {31'h0, bus.cfg_enable}, 32'h0);
            if (burst) chk("rd.wait_stop", {31'h0, bus.stop_n}, 32'h0);
        end
        if (abandon) drive(1'b1, 1'b1, 1'b0, $urandom, 4'($urandom));
        else         drive(burst ? 1'b0 : 1'b1, 1'b0, 1'b0, $urandom, 4'($urandom));
        chk("rd.tar_en", {31'h0, bus.cfg_enable}, 32'h0);
        chk_tar("rd");
        idle(1);
        chk_released("rd");
    endtask

    // Address phase that must not be claimed, followed by cfg-looking data.
    task automatic do_miss(input int kind);
        logic [31:0] a;
        logic [3:0]  cmd;
        logic        sel;
        a   = cfg_addr(3'd0, 6'($urandom));
        cmd = ($urandom % 2) ? CMD_CFG_WR : CMD_CFG_RD;
        sel = 1'b1;
        case (kind)
            0:       sel = 1'b0;
            1:       a[1:0] = 2'b01;
            2:       a[10:8] = 3'd1 + 3'($urandom_range(0, 6));
            3:       cmd = 4'b0110;
            default: cmd = 4'($urandom_range(0, 9));
        endcase
        idle(2);
        drive(1'b0, 1'b1, sel, a, cmd);
        chk("miss.devsel", {31'h0, bus.devsel_n}, 32'h1);
        chk("miss.ctloe",  {31'h0, bus.ctl_oe}, 32'h0);
        chk("miss.en",     {31'h0, bus.cfg_enable}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'($urandom), 1'b1, cfg_addr(3'd0, 6'($urandom)), CMD_CFG_WR);
            chk("miss.burst_dev", {31'h0, bus.devsel_n}, 32'h1);
            chk("miss.burst_oe",  {31'h0, bus.ctl_oe}, 32'h0);
            chk("miss.burst_en",  {31'h0, bus.cfg_enable}, 32'h0);
        end
        drive(1'b1, 1'b0, 1'b1, cfg_addr(3'd0, 6'($urandom)), CMD_CFG_RD);
        chk("miss.last_dev", {31'h0, bus.devsel_n}, 32'h1);
        chk("miss.last_en",  {31'h0, bus.cfg_enable}, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        bus.cfg_read_val = '0;
        idle(3);
        chk_reset("por");
        rst = 1'b1;
        idle(2);
        chk_released("por_idle");

        // Directed cases
        do_write(6'h04, 32'hFEBF_0000, 4'hF, 0, 1'b0, 1'b0);
        do_read(6'h00, 32'h11E8_1234, 0, 1'b0, 1'b0);
        do_read(6'h10, 32'hA5A5_5A5A, 5, 1'b0, 1'b0);
        do_write(6'h3F, 32'h1234_5678, 4'h3, 0, 1'b1, 1'b0);
        do_write(6'h21, 32'hCAFE_F00D, 4'h9, 2, 1'b1, 1'b0);
        do_read(6'h2A, 32'h0BAD_BEEF, 2, 1'b1, 1'b0);
        do_write(6'h05, 32'hDEAD_0001, 4'hF, 1, 1'b0, 1'b1);
        do_read(6'h06, 32'h7777_0001, 1, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) do_miss(k);

        // Reset while a read is in its data phase
        bus.cfg_read_val = 32'h5555_AAAA;
        idle(2);
        drive(1'b0, 1'b1, 1'b1, cfg_addr(3'd0, 6'h0C), CMD_CFG_RD);
        n_exp_strobes++;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 4'h0);
        chk("rstrd.pre_ad", bus.ad_out, 32'h5555_AAAA);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
        chk_reset("rst_rd");
        rst = 1'b1;
        do_read(6'h0D, 32'h1357_2468, 0, 1'b0, 1'b0);

        // Reset while a write waits for IRDY#
        idle(2);
        drive(1'b0, 1'b1, 1'b1, cfg_addr(3'd0, 6'h1C), CMD_CFG_WR);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 4'h0);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'h0);
        chk_reset("rst_wr");
        rst = 1'b1;
        idle(1);
        chk("rst_wr.no_strobe", {31'h0, bus.cfg_enable}, 32'h0);
        do_write(6'h1D, 32'h2468_1357, 4'hC, 0, 1'b0, 1'b0);

        // Randomized mix
        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1: do_write(6'($urandom), $urandom, 4'($urandom), $urandom_range(0, 4),
                               1'($urandom), ($urandom_range(0, 5) == 0));
                2, 3: do_read(6'($urandom), $urandom, $urandom_range(0, 4),
                              1'($urandom), ($urandom_range(0, 5) == 0));
                default: do_miss($urandom_range(0, 4));
            endcase
        end

        idle(2);
        chk("strobe_count", n_seen_strobes, n_exp_strobes);
        chk("strobe_b2b", n_consec, 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
